// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: datapath width, special encodings and fetch FSM states.
package mips_pkg;

  localparam int unsigned LEN          = 32;
  localparam int unsigned IMEM_AW_DEF  = 10;
  localparam int unsigned PC_INC       = 4;

  localparam logic [LEN-1:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [LEN-1:0] HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  // Word-aligns a byte address.
  function automatic logic [LEN-1:0] word_align(input logic [LEN-1:0] addr);
    return addr & ~LEN'(3);
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// Instruction RAM: asynchronous read port for fetch, synchronous write port for the debug loader.
module instruction_memory
  import mips_pkg::*;
#(
  parameter int unsigned NB_IMEM_ADDR = IMEM_AW_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic [NB_IMEM_ADDR-1:0] i_waddr,
  input  logic [LEN-1:0]          i_wdata,
  input  logic [NB_IMEM_ADDR-1:0] i_raddr,
  output logic [LEN-1:0]          o_rdata_c
);

  localparam int unsigned DEPTH = 1 << NB_IMEM_ADDR;

  logic [LEN-1:0] mem_q [DEPTH];

  // Contents deliberately survive reset so a loaded program can be rerun.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_c = mem_q[i_raddr];

endmodule

// File: rtl/seg_instruction_fetch.sv
// IF stage: PC, instruction memory, IF/ID register and a RUN/HALT fetch controller.
module seg_instruction_fetch
  import mips_pkg::*;
#(
  parameter int unsigned NB_IMEM_ADDR = IMEM_AW_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic                    i_stall,
  input  logic                    i_branch_taken,
  input  logic [LEN-1:0]          i_branch_target,
  input  logic                    i_jump,
  input  logic [LEN-1:0]          i_jump_target,
  input  logic                    i_prog_we,
  input  logic [NB_IMEM_ADDR-1:0] i_prog_addr,
  input  logic [LEN-1:0]          i_prog_data,
  output logic [LEN-1:0]          o_PC,
  output logic [LEN-1:0]          o_instruc,
  output logic                    o_valid,
  output logic                    o_halt,
  output logic [LEN-1:0]          o_cycle_count
);

  fetch_state_e   state_q;
  logic [LEN-1:0] pc_q;
  logic [LEN-1:0] ifid_pc_q;
  logic [LEN-1:0] ifid_instr_q;
  logic           ifid_valid_q;
  logic [LEN-1:0] cycle_cnt_q;

  logic [LEN-1:0] fetch_word_c;
  logic [LEN-1:0] pc_plus4_c;
  logic           redirect_c;
  logic [LEN-1:0] redirect_tgt_c;

  instruction_memory #(
    .NB_IMEM_ADDR (NB_IMEM_ADDR)
  ) u_imem (
    .i_clk     (i_clk),
    .i_we      (i_prog_we),
    .i_waddr   (i_prog_addr),
    .i_wdata   (i_prog_data),
    .i_raddr   (pc_q[NB_IMEM_ADDR+1:2]),
    .o_rdata_c (fetch_word_c)
  );

  // Branch is the older instruction, so it wins over a simultaneous jump.
  assign redirect_c     = i_branch_taken | i_jump;
  assign redirect_tgt_c = i_branch_taken ? i_branch_target : i_jump_target;
  assign pc_plus4_c     = pc_q + LEN'(PC_INC);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_RUN;
      pc_q         <= '0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      cycle_cnt_q  <= '0;
    end else if (i_enable) begin
      if (state_q == ST_RUN) begin
        cycle_cnt_q <= cycle_cnt_q + LEN'(1);
      end

      if (redirect_c) begin
        // Flush the wrong-path instruction; also cancels a speculative HALT.
        pc_q         <= word_align(redirect_tgt_c);
        ifid_pc_q    <= '0;
        ifid_instr_q <= NOP_INSTR;
        ifid_valid_q <= 1'b0;
        state_q      <= ST_RUN;
      end else if (!i_stall) begin
        if (state_q == ST_HALT) begin
          ifid_pc_q    <= '0;
          ifid_instr_q <= NOP_INSTR;
          ifid_valid_q <= 1'b0;
        end else begin
          ifid_pc_q    <= pc_plus4_c;
          ifid_instr_q <= fetch_word_c;
          ifid_valid_q <= 1'b1;
          // The HALT word still travels down the pipe; only the PC freezes.
          if (fetch_word_c == HALT_INSTR) begin
            state_q <= ST_HALT;
          end else begin
            pc_q <= pc_plus4_c;
          end
        end
      end
    end
  end

  assign o_PC          = ifid_pc_q;
  assign o_instruc     = ifid_instr_q;
  assign o_valid       = ifid_valid_q;
  assign o_halt        = (state_q == ST_HALT);
  assign o_cycle_count = cycle_cnt_q;

endmodule
